wbuf_drain: RTL and testbench
=============================

WBUF_DRAIN -- requirements
Module: wbuf_drain

Interface
REQ-001 Parameters: W_ADDR, 32, address width.
REQ-002 Parameters: W_DATA, 32, data width; W_STRB fixed as W_DATA/8.
REQ-003 Parameters: C_TIMEOUT, 255, REQ-state cycles without MemReady_i before abort.
REQ-004 Parameters: C_MAXRETRY, 3, aborts tolerated per entry before the entry is dropped.
REQ-005 Clock and reset: single clock; reset is synchronous and active-low; all state changes on the rising edge of sClk_i.
REQ-006 sClk_i  in  1  clock.
REQ-007 snRst_i  in  1  synchronous active-low reset.
REQ-008 Empty_i  in  1  upstream write-buffer FIFO empty.
REQ-009 ReadData_i  in  W_ADDR+W_DATA+W_STRB  FIFO head word; layout {addr, data, strb}, strb in the LSBs; valid combinationally while Empty_i=0.
REQ-010 Read_o  out  1  FIFO pop, combinational, one cycle per entry.
REQ-011 Stall_i  in  1  inhibit new pops; the entry in flight completes.
REQ-012 CompareAddr_i  in  W_ADDR  address for the hazard check against the held entry.
REQ-013 HoldHit_o  out  1  held entry valid and address equals CompareAddr_i, combinational.
REQ-014 Busy_o  out  1  entry held, i.e. state is not IDLE.
REQ-015 Error_o  out  1  sticky; set when an entry is dropped.
REQ-016 ErrClr_i  in  1  clears Error_o.
REQ-017 MemValid_o  out  1  memory write request.
REQ-018 MemAddr_o, MemWData_o, MemWStrb_o  out  W_ADDR/W_DATA/W_STRB  request payload, driven from hold registers.
REQ-019 MemReady_i  in  1  memory accepts the request in a cycle where MemValid_o=1.

Function
REQ-020 States: IDLE, REQ, BACKOFF.
REQ-021 IDLE: if Empty_i=0 and Stall_i=0, the block asserts Read_o, latches ReadData_i into the hold registers, clears the timeout and retry counters, and moves to REQ.
REQ-022 Entry capture occurs in the same cycle as Read_o, because the FIFO clears the slot on pop.
REQ-023 REQ: MemValid_o=1; the payload stays stable until accepted.
REQ-024 REQ with MemReady_i=1: entry retired. If Empty_i=0 and Stall_i=0 in that cycle, the block pops the next entry with Read_o=1, reloads the holds, clears the counters and stays in REQ (back-to-back, one entry per cycle max). Otherwise it goes to IDLE.
REQ-025 REQ with MemReady_i=0: the timeout counter increments. When it reaches C_TIMEOUT, the block goes to BACKOFF and increments the retry counter.
REQ-026 BACKOFF lasts one cycle with MemValid_o=0. If the retry count equals C_MAXRETRY, the entry is dropped, Error_o is set and the state goes to IDLE. Otherwise the timeout counter is cleared and the state returns to REQ with the same payload.
REQ-027 MemReady_i is ignored when MemValid_o=0.
REQ-028 Read_o is never asserted when Empty_i=1, Stall_i=1 or in BACKOFF.
REQ-029 HoldHit_o is 0 in IDLE and is valid in REQ and BACKOFF. The block ORs it externally with the FIFO compare vector to complete the hazard check.
REQ-030 Error_o: set has priority over ErrClr_i in the same cycle.
REQ-031 Stall_i rising during REQ does not abort the held entry.
REQ-032 Counter widths are $clog2(C_TIMEOUT+1) and $clog2(C_MAXRETRY+1); counters never wrap.

Reset
REQ-033 When snRst_i=0 at a clock edge: state IDLE, hold registers 0, counters 0, Error_o=0.
REQ-034 Outputs after reset: MemValid_o=0, Read_o=0, Busy_o=0, HoldHit_o=0, payload 0.
REQ-035 Reset asserted mid-transaction discards the held entry with no pop or request on the following cycle.

Structure
REQ-036 A shared cache package holds the entry field offsets (strb/data/addr LSB positions), the entry width function and the state encoding.
REQ-037 No sub-module is required; the timeout/retry counter pair may be one sub-module, wbuf_retry_ctr.

Verification
REQ-038 Single entry {0x0000_1000, 0xDEAD_BEEF, 0xF}, MemReady_i=1 the cycle after the pop -> Read_o for one cycle, MemValid_o for one cycle with that payload, then IDLE and Busy_o=0.
REQ-039 Three entries queued, MemReady_i held at 1 -> three consecutive accepts, Read_o high for 3 consecutive cycles, no bubbles.
REQ-040 Entry held with CompareAddr_i=0x0000_1000 -> HoldHit_o=1; after accept and a return to IDLE -> HoldHit_o=0.
REQ-041 C_TIMEOUT=4, C_MAXRETRY=2, MemReady_i=0 -> two BACKOFF cycles with MemValid_o=0, then drop, Error_o=1, IDLE. ErrClr_i pulse -> Error_o=0.
REQ-042 snRst_i=0 during REQ with the FIFO non-empty -> next cycle MemValid_o=0 and Read_o=0, all holds 0, and popping resumes after release.
REQ-043 Stall_i=1 with the FIFO non-empty -> no Read_o; the in-flight entry still completes on MemReady_i.

Source files
------------

// File: rtl/wbuf_drain_pkg.sv
// Shared definitions for the write-buffer drain: entry field layout and FSM state encoding.
// Entry layout is {addr, data, strb} with strb in the LSBs.
package wbuf_drain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_BACKOFF = 2'd2
   } state_t;

   function automatic int strb_lsb(input int w_data);
      return 0 * w_data;
   endfunction

   function automatic int data_lsb(input int w_data);
      return w_data / 8;
   endfunction

   function automatic int addr_lsb(input int w_data);
      return w_data + w_data / 8;
   endfunction

   function automatic int entry_width(input int w_addr, input int w_data);
      return w_addr + w_data + w_data / 8;
   endfunction

endpackage

// File: rtl/wbuf_drain_if.sv
// Memory write-request channel: the drain (master) issues valid + payload, memory (slave) returns ready.
interface wbuf_drain_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   localparam int W_STRB = W_DATA / 8;

   logic              MemValid_o;
   logic [W_ADDR-1:0] MemAddr_o;
   logic [W_DATA-1:0] MemWData_o;
   logic [W_STRB-1:0] MemWStrb_o;
   logic              MemReady_i;

   modport master (
      output MemValid_o, MemAddr_o, MemWData_o, MemWStrb_o,
      input  MemReady_i
   );

   modport slave (
      input  MemValid_o, MemAddr_o, MemWData_o, MemWStrb_o,
      output MemReady_i
   );

endinterface

// File: rtl/wbuf_drain.sv
// Drains a write-buffer FIFO into a memory write port, one entry per cycle at best, with
// timeout/retry abort per entry; the FIFO pop and the entry capture happen in the same cycle.
module wbuf_drain
   import wbuf_drain_pkg::*;
#(
   parameter int W_ADDR     = 32,
   parameter int W_DATA     = 32,
   parameter int C_TIMEOUT  = 255,
   parameter int C_MAXRETRY = 3
)(
   input  logic                                    sClk_i,
   input  logic                                    snRst_i,
   input  logic                                    Empty_i,
   input  logic [entry_width(W_ADDR, W_DATA)-1:0]  ReadData_i,
   output logic                                    Read_o,
   input  logic                                    Stall_i,
   input  logic [W_ADDR-1:0]                       CompareAddr_i,
   output logic                                    HoldHit_o,
   output logic                                    Busy_o,
   output logic                                    Error_o,
   input  logic                                    ErrClr_i,
   wbuf_drain_if.master                            mem
);

   localparam int W_STRB   = W_DATA / 8;
   localparam int STRB_LSB = strb_lsb(W_DATA);
   localparam int DATA_LSB = data_lsb(W_DATA);
   localparam int ADDR_LSB = addr_lsb(W_DATA);
   localparam int W_TMO    = $clog2(C_TIMEOUT + 1);
   localparam int W_RTY    = $clog2(C_MAXRETRY + 1);

   localparam logic [W_TMO-1:0] TMO_LAST = W_TMO'(C_TIMEOUT - 1);
   localparam logic [W_RTY-1:0] RTY_MAX  = W_RTY'(C_MAXRETRY);

   state_t            state_q, state_d;
   logic [W_ADDR-1:0] hold_addr_q;
   logic [W_DATA-1:0] hold_data_q;
   logic [W_STRB-1:0] hold_strb_q;
   logic [W_TMO-1:0]  tmo_q;
   logic [W_RTY-1:0]  rty_q;
   logic              err_q;

   logic pop, can_pop, tmo_inc, tmo_clr, rty_inc, drop;

   // Gating with reset keeps the FIFO from losing an entry while the holds are being cleared.
   assign can_pop = !Empty_i && !Stall_i && snRst_i;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      tmo_inc = 1'b0;
      tmo_clr = 1'b0;
      rty_inc = 1'b0;
      drop    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (can_pop) begin
               pop     = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem.MemReady_i) begin
               if (can_pop) pop = 1'b1;
               else         state_d = ST_IDLE;
            end else begin
               tmo_inc = 1'b1;
               if (tmo_q == TMO_LAST) begin
                  rty_inc = 1'b1;
                  state_d = ST_BACKOFF;
               end
            end
         end
         ST_BACKOFF: begin
            if (rty_q == RTY_MAX) begin
               drop    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_clr = 1'b1;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sClk_i) begin
      if (!snRst_i) begin
         state_q     <= ST_IDLE;
         hold_addr_q <= '0;
         hold_data_q <= '0;
         hold_strb_q <= '0;
         tmo_q       <= '0;
         rty_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            hold_addr_q <= ReadData_i[ADDR_LSB +: W_ADDR];
            hold_data_q <= ReadData_i[DATA_LSB +: W_DATA];
            hold_strb_q <= ReadData_i[STRB_LSB +: W_STRB];
            tmo_q       <= '0;
            rty_q       <= '0;
         end else begin
            if (tmo_clr)      tmo_q <= '0;
            else if (tmo_inc) tmo_q <= tmo_q + W_TMO'(1);
            if (rty_inc)      rty_q <= rty_q + W_RTY'(1);
         end
         // A drop in the same cycle as a clear request must still be reported.
         if (drop)          err_q <= 1'b1;
         else if (ErrClr_i) err_q <= 1'b0;
      end
   end

   assign Read_o         = pop;
   assign Busy_o         = (state_q != ST_IDLE);
   assign HoldHit_o      = Busy_o && (hold_addr_q == CompareAddr_i);
   assign Error_o        = err_q;
   assign mem.MemValid_o = (state_q == ST_REQ);
   assign mem.MemAddr_o  = hold_addr_q;
   assign mem.MemWData_o = hold_data_q;
   assign mem.MemWStrb_o = hold_strb_q;

endmodule

// File: tb/tb_wbuf_drain.sv
// Scoreboard bench for wbuf_drain: FIFO and memory are modelled per entry (wait-before-ready count);
// a monitor predicts accept/drop, latency and backoff count for each entry from that count.
module tb_wbuf_drain;

   localparam int TMO     = 4;
   localparam int RTY     = 2;
   localparam int DROP_AT = TMO * RTY;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          wt;
      bit          drop;
   } ent_t;

   logic        sClk_i = 1'b0;
   logic        snRst_i;
   logic        Empty_i;
   logic [67:0] ReadData_i;
   logic        Read_o;
   logic        Stall_i;
   logic [31:0] CompareAddr_i;
   logic        HoldHit_o;
   logic        Busy_o;
   logic        Error_o;
   logic        ErrClr_i;

   wbuf_drain_if #(.W_ADDR(32), .W_DATA(32)) mem_if ();

   wbuf_drain #(.W_ADDR(32), .W_DATA(32), .C_TIMEOUT(TMO), .C_MAXRETRY(RTY)) dut (
      .sClk_i(sClk_i), .snRst_i(snRst_i), .Empty_i(Empty_i), .ReadData_i(ReadData_i),
      .Read_o(Read_o), .Stall_i(Stall_i), .CompareAddr_i(CompareAddr_i),
      .HoldHit_o(HoldHit_o), .Busy_o(Busy_o), .Error_o(Error_o), .ErrClr_i(ErrClr_i),
      .mem(mem_if.master)
   );

   always #5 sClk_i = ~sClk_i;

   int   n_vec = 0, n_err = 0;
   int   n_pop = 0, n_done = 0;
   int   vcyc = 0, bo = 0;
   int   cur_wait = 0, vcnt = 0;
   bit   err_prev = 1'b0;
   ent_t fifo_q[$];
   ent_t exp_q[$];

   task automatic chk(input string nm, input longint act, input longint req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic flag_fail(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: bound expired (t=%0t)", nm, $time);
   endtask

   task automatic drive_fifo();
      if (fifo_q.size() == 0) begin
         Empty_i    = 1'b1;
         ReadData_i = '0;
      end else begin
         Empty_i    = 1'b0;
         ReadData_i = {fifo_q[0].addr, fifo_q[0].data, fifo_q[0].strb};
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int wt);
      ent_t e;
      e.addr = a; e.data = d; e.strb = s; e.wt = wt;
      e.drop = (wt >= DROP_AT);
      fifo_q.push_back(e);
      exp_q.push_back(e);
      drive_fifo();
   endtask

   function automatic int rand_wait();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 12) return int'($urandom_range(0, 2));
      if (r < 17) return int'($urandom_range(3, 7));
      return int'($urandom_range(DROP_AT, DROP_AT + 4));
   endfunction

   task automatic wait_valid(input string nm, input int lim);
      int k;
      k = 0;
      do begin
         @(negedge sClk_i);
         k++;
      end while (!mem_if.MemValid_o && k < lim);
      if (!mem_if.MemValid_o) flag_fail(nm);
   endtask

   task automatic wait_idle(input string nm, input int lim);
      int k;
      k = 0;
      while (k < lim && !(fifo_q.size() == 0 && n_pop == n_done && !Busy_o)) begin
         @(negedge sClk_i);
         k++;
      end
      if (k >= lim) flag_fail(nm);
   endtask

   // Memory + FIFO model: each entry withholds ready for its first wt request cycles.
   initial begin
      mem_if.MemReady_i = 1'b0;
      forever begin
         bit   pop;
         ent_t e;
         @(negedge sClk_i);
         pop = Read_o;
         if (mem_if.MemValid_o && !mem_if.MemReady_i) vcnt++;
         @(posedge sClk_i);
         #1;
         if (pop && fifo_q.size() > 0) begin
            e        = fifo_q.pop_front();
            cur_wait = e.wt;
            vcnt     = 0;
            n_pop++;
            drive_fifo();
         end
         mem_if.MemReady_i = (vcnt >= cur_wait);
      end
   end

   // Monitor: retires entries on accept or on the Error_o rising edge and checks every cycle.
   initial begin
      forever begin
         bit   in_fl;
         ent_t e;
         @(negedge sClk_i);
         if (Error_o && !err_prev) begin
            if (exp_q.size() == 0) begin
               flag_fail("drop_with_no_entry");
            end else begin
               e = exp_q.pop_front();
               chk("drop_predicted", longint'(e.drop), 1);
               chk("drop_backoffs", longint'(bo), RTY);
               chk("drop_req_cycles", longint'(vcyc), DROP_AT);
               n_done++;
            end
            vcyc = 0;
            bo   = 0;
         end
         err_prev = Error_o;
         in_fl = (n_pop != n_done) && (exp_q.size() > 0);
         chk("busy", longint'(Busy_o), longint'(in_fl));
         chk("read_gate", longint'(Read_o & (Empty_i | Stall_i)), 0);
         if (in_fl) begin
            chk("hold_hit", longint'(HoldHit_o), longint'(CompareAddr_i == exp_q[0].addr));
            if (mem_if.MemValid_o) begin
               chk("mem_addr", longint'(mem_if.MemAddr_o), longint'(exp_q[0].addr));
               chk("mem_wdata", longint'(mem_if.MemWData_o), longint'(exp_q[0].data));
               chk("mem_wstrb", longint'(mem_if.MemWStrb_o), longint'(exp_q[0].strb));
            end
         end else begin
            chk("hold_hit_idle", longint'(HoldHit_o), 0);
            chk("valid_idle", longint'(mem_if.MemValid_o), 0);
         end
         if (mem_if.MemValid_o) vcyc++;
         else if (Busy_o)       bo++;
         if (mem_if.MemValid_o && mem_if.MemReady_i && in_fl) begin
            e = exp_q.pop_front();
            chk("accept_predicted", longint'(e.drop), 0);
            chk("accept_latency", longint'(vcyc), longint'(e.wt + 1));
            chk("accept_backoffs", longint'(bo), longint'(e.wt / TMO));
            n_done++;
            vcyc = 0;
            bo   = 0;
         end
      end
   end

   initial begin
      int rd, vd, hh, run, maxrun, arun, amax, bo2, k;
      snRst_i = 1'b0; Empty_i = 1'b1; ReadData_i = '0; Stall_i = 1'b0;
      CompareAddr_i = '0; ErrClr_i = 1'b0;
      repeat (3) @(posedge sClk_i);
      #1;
      push(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0);
      @(negedge sClk_i);
      chk("rst_read", longint'(Read_o), 0);
      chk("rst_valid", longint'(mem_if.MemValid_o), 0);
      chk("rst_busy", longint'(Busy_o), 0);
      chk("rst_hold_hit", longint'(HoldHit_o), 0);
      chk("rst_addr", longint'(mem_if.MemAddr_o), 0);
      chk("rst_wdata", longint'(mem_if.MemWData_o), 0);
      chk("rst_wstrb", longint'(mem_if.MemWStrb_o), 0);
      chk("rst_error", longint'(Error_o), 0);

      // Single entry, immediate accept.
      @(posedge sClk_i); #1;
      snRst_i = 1'b1;
      CompareAddr_i = 32'h0000_1000;
      rd = 0; vd = 0; hh = 0;
      repeat (6) begin
         @(negedge sClk_i);
         rd += int'(Read_o);
         vd += int'(mem_if.MemValid_o);
         if (mem_if.MemValid_o) hh += int'(HoldHit_o);
      end
      chk("single_read_cycles", longint'(rd), 1);
      chk("single_valid_cycles", longint'(vd), 1);
      chk("single_hold_hit", longint'(hh), 1);
      chk("single_busy_after", longint'(Busy_o), 0);
      chk("hold_hit_after_idle", longint'(HoldHit_o), 0);

      // Three queued entries drain back-to-back.
      @(posedge sClk_i); #1;
      for (int i = 0; i < 3; i++) push(32'h2000 + 32'(i), $urandom(), 4'(i + 3), 0);
      rd = 0; run = 0; maxrun = 0; arun = 0; amax = 0;
      repeat (8) begin
         @(negedge sClk_i);
         rd += int'(Read_o);
         run = Read_o ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
         arun = (mem_if.MemValid_o && mem_if.MemReady_i) ? arun + 1 : 0;
         if (arun > amax) amax = arun;
      end
      chk("b2b_reads", longint'(rd), 3);
      chk("b2b_read_run", longint'(maxrun), 3);
      chk("b2b_accept_run", longint'(amax), 3);

      // Memory never ready: two backoffs then drop.
      @(posedge sClk_i); #1;
      push(32'h5000, $urandom(), 4'hC, 100);
      bo2 = 0; k = 0;
      do begin
         @(negedge sClk_i);
         if (Busy_o && !mem_if.MemValid_o) bo2++;
         k++;
      end while (!Error_o && k < 60);
      if (!Error_o) flag_fail("drop_error_wait");
      chk("drop_backoff_cycles", longint'(bo2), 2);
      chk("drop_idle", longint'(Busy_o), 0);
      @(posedge sClk_i); #1; ErrClr_i = 1'b1;
      @(posedge sClk_i); #1; ErrClr_i = 0;
      @(negedge sClk_i);
      chk("error_cleared", longint'(Error_o), 0);

      // Drop while clear is held: set wins for that cycle.
      @(posedge sClk_i); #1;
      ErrClr_i = 1'b1;
      push(32'h6000, $urandom(), 4'h1, DROP_AT + 1);
      k = 0;
      do begin
         @(negedge sClk_i);
         k++;
      end while (!Error_o && k < 60);
      chk("error_set_priority", longint'(Error_o), 1);
      @(posedge sClk_i); #1; ErrClr_i = 1'b0;
      @(negedge sClk_i);
      chk("error_clear_after_set", longint'(Error_o), 0);

      // Reset in the middle of a request with more entries queued.
      @(posedge sClk_i); #1;
      for (int i = 0; i < 3; i++) push(32'h7000 + 32'(i), $urandom(), 4'hA, 3);
      wait_valid("rst_mid_wait_valid", 10);
      @(posedge sClk_i); #1; snRst_i = 1'b0;
      @(posedge sClk_i); #1;
      if (n_pop != n_done) begin
         void'(exp_q.pop_front());
         n_done++;
      end
      vcyc = 0; bo = 0;
      @(negedge sClk_i);
      chk("rst_mid_valid", longint'(mem_if.MemValid_o), 0);
      chk("rst_mid_read", longint'(Read_o), 0);
      chk("rst_mid_busy", longint'(Busy_o), 0);
      chk("rst_mid_addr", longint'(mem_if.MemAddr_o), 0);
      chk("rst_mid_wdata", longint'(mem_if.MemWData_o), 0);
      chk("rst_mid_wstrb", longint'(mem_if.MemWStrb_o), 0);
      @(posedge sClk_i); #1; snRst_i = 1'b1;
      wait_idle("rst_mid_resume", 60);

      // Stall with entries pending: in-flight entry completes, no new pops.
      @(posedge sClk_i); #1;
      push(32'h8000, $urandom(), 4'h5, 2);
      wait_valid("stall_wait_valid", 10);
      @(posedge sClk_i); #1;
      Stall_i = 1'b1;
      push(32'h9000, $urandom(), 4'h6, 0);
      rd = 0;
      repeat (8) begin
         @(negedge sClk_i);
         rd += int'(Read_o);
      end
      chk("stall_no_read", longint'(rd), 0);
      chk("stall_inflight_done", longint'(Busy_o), 0);
      @(posedge sClk_i); #1; Stall_i = 1'b0;
      wait_idle("stall_release_drain", 40);

      // Randomized traffic.
      @(posedge sClk_i); #1;
      ErrClr_i = 1'b1;
      repeat (600) begin
         @(posedge sClk_i); #1;
         if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0)
            push(32'($urandom_range(1, 9)) << 12, $urandom(), 4'($urandom_range(0, 15)), rand_wait());
         Stall_i = ($urandom_range(0, 4) == 0);
         if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) CompareAddr_i = exp_q[0].addr;
         else                                             CompareAddr_i = 32'($urandom_range(1, 9)) << 12;
      end
      Stall_i = 1'b0;
      wait_idle("random_drain", 300);
      chk("scoreboard_empty", longint'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
